debounce_sync: RTL and testbench

Conditioning front end that takes an asynchronous, bouncy single-bit input (push-button or switch) and produces a clean, clock-synchronous level `dout` suitable as the `D` input of the downstream D flip-flop stage. It runs a two-flop synchroniser, a debounce state machine and a stability counter, and can optionally emit one-cycle edge pulses. Every output is registered on `CLK`.

---
 rtl/debounce_sync.sv | 121 ++++++++++++
 tb/tb_debounce_sync.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser, debounce FSM and stability counter for a bouncy input.
// Optional rise/fall edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
`timescale 1ps/1ps

module debounce_sync #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 3
) (
    input  logic CLK,
    input  logic res,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // The counter must be able to reach STABLE_CNT without wrapping.
    generate
        if (STABLE_CNT < 1 || STABLE_CNT > (2**CNT_W) - 1) begin : g_bad_cfg
            $error("debounce_sync: STABLE_CNT=%0d out of range for CNT_W=%0d", STABLE_CNT, CNT_W);
        end
    endgenerate

    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (res) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // A glitch back to the current level at any point in CHK_* drops the count entirely.
    always_ff @(posedge CLK) begin
        if (res) begin
            state <= IDLE_LO;
            cnt   <= '0;
            dout  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            rise  <= 1'b0;
            fall  <= 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_EDGE_EN
            rise <= 1'b0;
            fall <= 1'b0;
`endif
            case (state)
                IDLE_LO: begin
                    if (s2) begin
                        state <= CHK_HI;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!s2) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LIMIT) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        dout  <= 1'b1;
`ifdef DEBOUNCE_EDGE_EN
                        rise  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s2) begin
                        state <= CHK_LO;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_LO: begin
                    if (s2) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LIMIT) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        dout  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
                        fall  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

`ifndef DEBOUNCE_EDGE_EN
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed scenarios for debounce_sync at STABLE_CNT=4, CNT_W=3, 100 ps clock.
// Expected pulse values follow DEBOUNCE_EDGE_EN the same way the design build does.
`timescale 1ps/1ps

module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic CLK;
    logic res;
    logic din;
    logic dout;
    logic rise;
    logic fall;

    int total = 0;
    int bad   = 0;

    debounce_sync #(.STABLE_CNT(4), .CNT_W(3)) dut (
        .CLK  (CLK),
        .res  (res),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    task automatic drive(input logic d, input logic r);
        @(negedge CLK);
        din = d;
        res = r;
    endtask

    task automatic tick();
        @(posedge CLK);
        #20;
    endtask

    task automatic test_reset();
        din = 1'b1;
        res = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (dout !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout k=%0d got=%b want=0", k, dout); end
            total++;
            if (rise !== 1'b0) begin bad++; $display("[TB] FAIL reset_rise k=%0d got=%b want=0", k, rise); end
            total++;
            if (fall !== 1'b0) begin bad++; $display("[TB] FAIL reset_fall k=%0d got=%b want=0", k, fall); end
        end
        drive(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (dout !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_dout k=%0d got=%b want=0", k, dout); end
        end
    endtask

    // Drives a new steady level captured at E0 and checks E0..E8.
    task automatic test_clean_edge(input logic level);
        logic exp_dout, exp_rise, exp_fall;
        drive(level, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            tick();
            exp_dout = (k >= 6) ? level : ~level;
            exp_rise = EDGE_EN & level & (k == 6);
            exp_fall = EDGE_EN & ~level & (k == 6);
            total++;
            if (dout !== exp_dout) begin bad++; $display("[TB] FAIL clean_%0b_dout E%0d got=%b want=%b", level, k, dout, exp_dout); end
            total++;
            if (rise !== exp_rise) begin bad++; $display("[TB] FAIL clean_%0b_rise E%0d got=%b want=%b", level, k, rise, exp_rise); end
            total++;
            if (fall !== exp_fall) begin bad++; $display("[TB] FAIL clean_%0b_fall E%0d got=%b want=%b", level, k, fall, exp_fall); end
        end
    endtask

    // Pulses din to `level` for `ncap` captured cycles; too short to pass, so dout holds.
    task automatic test_glitch(input logic level, input int ncap);
        drive(level, 1'b0);
        for (int k = 0; k < ncap; k++) tick();
        drive(~level, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (dout !== ~level) begin bad++; $display("[TB] FAIL glitch_%0b_%0d_dout k=%0d got=%b want=%b", level, ncap, k, dout, ~level); end
            total++;
            if (rise !== 1'b0) begin bad++; $display("[TB] FAIL glitch_%0b_%0d_rise k=%0d got=%b want=0", level, ncap, k, rise); end
            total++;
            if (fall !== 1'b0) begin bad++; $display("[TB] FAIL glitch_%0b_%0d_fall k=%0d got=%b want=0", level, ncap, k, fall); end
        end
    endtask

    // Shortest accepted pulse (5 captures): dout high E6..E10, back low at E11.
    task automatic test_back_to_back();
        logic exp_dout, exp_rise, exp_fall;
        drive(1'b1, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 4) drive(1'b0, 1'b0);
            exp_dout = (k >= 6 && k <= 10);
            exp_rise = EDGE_EN & (k == 6);
            exp_fall = EDGE_EN & (k == 11);
            total++;
            if (dout !== exp_dout) begin bad++; $display("[TB] FAIL minpulse_dout E%0d got=%b want=%b", k, dout, exp_dout); end
            total++;
            if (rise !== exp_rise) begin bad++; $display("[TB] FAIL minpulse_rise E%0d got=%b want=%b", k, rise, exp_rise); end
            total++;
            if (fall !== exp_fall) begin bad++; $display("[TB] FAIL minpulse_fall E%0d got=%b want=%b", k, fall, exp_fall); end
        end
    endtask

    // Reset lands at E3 while counting; count restarts and dout rises at R6.
    task automatic test_reset_mid_count();
        logic exp_dout, exp_rise;
        drive(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (dout !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pre_dout E%0d got=%b want=0", k, dout); end
        end
        drive(1'b1, 1'b1);
        tick();
        total++;
        if (dout !== 1'b0) begin bad++; $display("[TB] FAIL midrst_at_reset_dout got=%b want=0", dout); end
        total++;
        if (rise !== 1'b0) begin bad++; $display("[TB] FAIL midrst_at_reset_rise got=%b want=0", rise); end
        drive(1'b1, 1'b0);
        for (int k = 0; k <= 7; k++) begin
            tick();
            exp_dout = (k >= 6);
            exp_rise = EDGE_EN & (k == 6);
            total++;
            if (dout !== exp_dout) begin bad++; $display("[TB] FAIL midrst_dout R%0d got=%b want=%b", k, dout, exp_dout); end
            total++;
            if (rise !== exp_rise) begin bad++; $display("[TB] FAIL midrst_rise R%0d got=%b want=%b", k, rise, exp_rise); end
            total++;
            if (fall !== 1'b0) begin bad++; $display("[TB] FAIL midrst_fall R%0d got=%b want=0", k, fall); end
        end
    endtask

    initial begin
        $display("[TB] debounce_sync bench start, edge pulses %s", EDGE_EN ? "enabled" : "disabled");
        test_reset();
        test_clean_edge(1'b1);
        test_glitch(1'b0, 3);
        test_clean_edge(1'b0);
        test_glitch(1'b1, 3);
        test_glitch(1'b1, 4);
        test_back_to_back();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
